// File: rtl/mont_mult_ctrl_if.sv
// Handshake and strobe bundle between the modexp FSM, the Montgomery
// multiply sequencer and the multiplier datapath.
interface mont_mult_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             start;
  logic             abort;
  logic             stall;
  logic             busy;
  logic             done;
  logic             sr_ena;
  logic             sr_clear_n;
  logic             sr_load;
  logic             acc_clear;
  logic             acc_step;
  logic             acc_final;
  logic [CNT_W-1:0] bit_idx;

  modport master (
    output start, abort, stall,
    input  busy, done, sr_ena, sr_clear_n, sr_load,
           acc_clear, acc_step, acc_final, bit_idx
  );

  modport slave (
    input  start, abort, stall,
    output busy, done, sr_ena, sr_clear_n, sr_load,
           acc_clear, acc_step, acc_final, bit_idx
  );
endinterface

// File: rtl/mont_mult_ctrl.sv
// Sequencer for one bit-serial Montgomery multiply: clears and loads the
// operand shift register, steps the accumulator WIDTH times, then finalises.
module mont_mult_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstb,
  mont_mult_ctrl_if.slave  mm_io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_ITER  = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Moore flags registered from the next state; stall gates the strobes below.
  logic busy_q, done_q, ena_q, clr_q, load_q, aclr_q, step_q, fin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mm_io.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (mm_io.start) state_d = S_CLEAR;
        end
        S_CLEAR: if (!mm_io.stall) state_d = S_LOAD;
        S_LOAD: begin
          if (!mm_io.stall) begin
            state_d = S_ITER;
            cnt_d   = '0;
          end
        end
        S_ITER: begin
          if (!mm_io.stall) begin
            if (cnt_q == LAST_IDX) state_d = S_FINAL;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        S_FINAL: if (!mm_io.stall) state_d = S_DONE;
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      clr_q   <= 1'b0;
      load_q  <= 1'b0;
      aclr_q  <= 1'b0;
      step_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      ena_q   <= (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_ITER);
      clr_q   <= (state_d == S_CLEAR);
      load_q  <= (state_d == S_LOAD);
      aclr_q  <= (state_d == S_CLEAR);
      step_q  <= (state_d == S_ITER);
      fin_q   <= (state_d == S_FINAL);
    end
  end

  // Strobes only exist in CLEAR/LOAD/ITER/FINAL, so a plain stall mask suffices.
  assign mm_io.busy       = busy_q;
  assign mm_io.done       = done_q;
  assign mm_io.sr_ena     = ena_q  & ~mm_io.stall;
  assign mm_io.sr_clear_n = ~(clr_q & ~mm_io.stall);
  assign mm_io.sr_load    = load_q & ~mm_io.stall;
  assign mm_io.acc_clear  = aclr_q & ~mm_io.stall;
  assign mm_io.acc_step   = step_q & ~mm_io.stall;
  assign mm_io.acc_final  = fin_q  & ~mm_io.stall;
  assign mm_io.bit_idx    = cnt_q;

endmodule

// File: tb/tb_mont_mult_ctrl.sv
// Directed, table-driven bench for the Montgomery multiply sequencer,
// with a behavioural LSB-first shift register on the strobes.
module tb_mont_mult_ctrl;

  localparam int WIDTH = 8;

  // Flag order: busy, done, sr_ena, sr_clear_n, sr_load, acc_clear, acc_step, acc_final
  localparam logic [7:0] F_IDLE  = 8'b0001_0000;
  localparam logic [7:0] F_CLEAR = 8'b1010_0100;
  localparam logic [7:0] F_LOAD  = 8'b1011_1000;
  localparam logic [7:0] F_ITER  = 8'b1011_0010;
  localparam logic [7:0] F_FINAL = 8'b1001_0001;
  localparam logic [7:0] F_DONE  = 8'b1101_0000;
  localparam logic [7:0] F_STALL = 8'b1001_0000;

  typedef struct packed {
    logic       rb;
    logic       st;
    logic       ab;
    logic       sl;
    logic [7:0] ef;
    logic [2:0] ei;
    logic       ci;
  } vec_t;

  logic clk = 1'b0;
  logic rstb;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  mont_mult_ctrl_if #(.WIDTH(WIDTH)) mm_if ();

  mont_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .mm_io (mm_if.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] sreg;
  always @(posedge clk) begin
    if (mm_if.sr_ena) begin
      if (!mm_if.sr_clear_n) sreg <= 8'h00;
      else if (mm_if.sr_load) sreg <= 8'hA5;
      else sreg <= sreg >> 1;
    end
  end

  function automatic logic [7:0] flags();
    return {mm_if.busy, mm_if.done, mm_if.sr_ena, mm_if.sr_clear_n,
            mm_if.sr_load, mm_if.acc_clear, mm_if.acc_step, mm_if.acc_final};
  endfunction

  task automatic check(input logic [7:0] ef, input logic [2:0] ei, input logic ci, input int id);
    n_tests++;
    if (flags() !== ef) begin
      n_fail++;
      $display("[TB] FAIL flags vec %0d: got %b expected %b", id, flags(), ef);
    end else
      $display("[TB] vec %0d flags %b ok", id, ef);
    if (ci) begin
      n_tests++;
      if (mm_if.bit_idx !== ei) begin
        n_fail++;
        $display("[TB] FAIL bit_idx vec %0d: got %0d expected %0d", id, mm_if.bit_idx, ei);
      end
    end
  endtask

  // Drive one cycle's inputs, check the outputs of that cycle, advance.
  task automatic step(input vec_t v, input int id);
    rstb     = v.rb;
    mm_if.start = v.st;
    mm_if.abort = v.ab;
    mm_if.stall = v.sl;
    #1;
    check(v.ef, v.ei, v.ci, id);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic ab, input logic sl,
                              input logic [7:0] ef, input logic [2:0] ei, input logic ci);
    return '{rb: 1'b1, st: st, ab: ab, sl: sl, ef: ef, ei: ei, ci: ci};
  endfunction

  initial begin
    int step_cnt;
    logic [7:0] cap;

    // Basic sequence: start in cycle 0, done in cycle 12.
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(0, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_LOAD, 3'd0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 0, F_ITER, 3'(k), 1));
    tbl.push_back(mk(0, 0, 0, F_FINAL, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_DONE, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_IDLE, 3'd0, 1));
    // Three stall cycles at bit_idx 4: done moves to cycle 15.
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(0, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_LOAD, 3'd0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, F_ITER, 3'(k), 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 1, F_STALL, 3'd4, 1));
    for (int k = 4; k < 8; k++) tbl.push_back(mk(0, 0, 0, F_ITER, 3'(k), 1));
    tbl.push_back(mk(0, 0, 0, F_FINAL, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_DONE, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_IDLE, 3'd0, 1));
    // Abort at bit_idx 2, no done, then a clean restart from bit 0.
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(0, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_LOAD, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_ITER, 3'd0, 1));
    tbl.push_back(mk(0, 0, 0, F_ITER, 3'd1, 1));
    tbl.push_back(mk(0, 1, 0, F_ITER, 3'd2, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(0, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_LOAD, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_ITER, 3'd0, 1));
    tbl.push_back(mk(0, 1, 1, F_STALL, 3'd1, 1));
    tbl.push_back(mk(0, 0, 0, F_IDLE, 3'd0, 1));
    // start held high: back-to-back, one IDLE cycle between operations.
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(1, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(1, 0, 0, F_LOAD, 3'd0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 0, 0, F_ITER, 3'(k), 1));
    tbl.push_back(mk(1, 0, 0, F_FINAL, 3'd0, 0));
    tbl.push_back(mk(1, 0, 0, F_DONE, 3'd0, 0));
    tbl.push_back(mk(1, 0, 0, F_IDLE, 3'd0, 1));
    tbl.push_back(mk(1, 0, 0, F_CLEAR, 3'd0, 0));
    tbl.push_back(mk(0, 1, 0, F_LOAD, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, F_IDLE, 3'd0, 1));

    rstb = 1'b0;
    mm_if.start = 1'b0;
    mm_if.abort = 1'b0;
    mm_if.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(F_IDLE, 3'd0, 1'b1, -1);

    foreach (tbl[i]) step(tbl[i], i);

    // Shift register pairing: A=8'hA5 presented LSB first on the 8 steps.
    cap = 8'h00;
    step_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      rstb = 1'b1;
      mm_if.start = (c == 0);
      mm_if.abort = 1'b0;
      mm_if.stall = 1'b0;
      #1;
      if (mm_if.acc_step) begin
        if (step_cnt < 8) cap[step_cnt] = sreg[0];
        step_cnt++;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (cap !== 8'hA5 || step_cnt != 8) begin
      n_fail++;
      $display("[TB] FAIL shiftreg bits: got %h in %0d steps expected a5 in 8", cap, step_cnt);
    end else
      $display("[TB] shiftreg bits %h over %0d steps ok", cap, step_cnt);

    // Reset pulse during FINAL, then start+abort held in IDLE.
    step(mk(1, 0, 0, F_IDLE, 3'd0, 1), 1000);
    step(mk(0, 0, 0, F_CLEAR, 3'd0, 0), 1001);
    step(mk(0, 0, 0, F_LOAD, 3'd0, 0), 1002);
    for (int k = 0; k < 8; k++) step(mk(0, 0, 0, F_ITER, 3'(k), 1), 1003 + k);
    begin
      vec_t v;
      v = mk(0, 0, 0, F_FINAL, 3'd0, 0);
      v.rb = 1'b0;
      step(v, 1011);
    end
    step(mk(0, 0, 0, F_IDLE, 3'd0, 1), 1012);
    for (int k = 0; k < 3; k++) step(mk(1, 1, 0, F_IDLE, 3'd0, 1), 1013 + k);
    step(mk(0, 0, 0, F_IDLE, 3'd0, 1), 1016);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
